// File: rtl/div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package div_pkg;

   localparam int CH_NUM_DEF  = 4;
   localparam int SRC_NUM_DEF = 3;
   localparam int DIV_W_DEF   = 8;
   localparam int SEL_W_DEF   = 2;

   localparam logic MODE_SQUARE = 1'b0;
   localparam logic MODE_PULSE  = 1'b1;

   // Square mode stays high for the first (act+1)/2 counts, so odd periods lean high.
   function automatic logic [31:0] sq_high_thr(input logic [31:0] act);
      return (act + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/div_chan.sv
// One divider channel: source select, shadow capture, boundary-synchronous
// divisor update, period counter and registered output.
module div_chan
   import div_pkg::*;
#(
   parameter int SRC_NUM = SRC_NUM_DEF,
   parameter int DIV_W   = DIV_W_DEF,
   parameter int SEL_W   = SEL_W_DEF
) (
   input  logic                       clk_i,
   input  logic                       rst_n,
   input  logic [SRC_NUM*DIV_W-1:0]   src_data,
   input  logic [SRC_NUM-1:0]         src_done,
   input  logic [SEL_W-1:0]           sel,
   input  logic                       mode,
   input  logic                       en,
   output logic                       div_en,
   output logic                       div_clk
);

   // Sources have no back-pressure: src_done is a one-cycle valid strobe for its
   // data slice, always accepted when this channel is enabled and selects it.
   logic [DIV_W-1:0] act, pend, cnt;
   logic             pv;

   logic [DIV_W-1:0] act_n, pend_n, cnt_n, cap_data;
   logic             pv_n, cap_hit, running, boundary, run_n, clk_n;

   always_comb begin
      cap_hit  = 1'b0;
      cap_data = '0;
      for (int s = 0; s < SRC_NUM; s++) begin
         if (sel == SEL_W'(s)) begin
            cap_hit  = src_done[s];
            cap_data = src_data[s*DIV_W +: DIV_W];
         end
      end

      running  = (act >= DIV_W'(2));
      boundary = running && (cnt == act - DIV_W'(1));

      act_n  = act;
      pend_n = pend;
      pv_n   = pv;
      cnt_n  = cnt;

      if (!en) begin
         act_n  = '0;
         pend_n = '0;
         pv_n   = 1'b0;
         cnt_n  = '0;
      end else begin
         if (running && !boundary) begin
            cnt_n = cnt + DIV_W'(1);
         end else begin
            // End of a period, or idle: the shadow divisor takes over here only.
            cnt_n = '0;
            if (pv) begin
               act_n = pend;
               pv_n  = 1'b0;
            end
         end
         if (cap_hit) begin
            pend_n = cap_data;
            pv_n   = 1'b1;
         end
      end

      run_n = (act_n >= DIV_W'(2));
      clk_n = 1'b0;
      if (run_n) begin
         if (mode == MODE_PULSE) begin
            clk_n = (cnt_n == '0);
         end else begin
            clk_n = (32'(cnt_n) < sq_high_thr(32'(act_n)));
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         act     <= '0;
         pend    <= '0;
         pv      <= 1'b0;
         cnt     <= '0;
         div_en  <= 1'b0;
         div_clk <= 1'b0;
      end else begin
         act     <= act_n;
         pend    <= pend_n;
         pv      <= pv_n;
         cnt     <= cnt_n;
         div_en  <= run_n;
         div_clk <= clk_n;
      end
   end

endmodule

// File: rtl/div_core_mc.sv
// Multi-channel programmable clock divider: one independent div_chan per output,
// each fed the full source bus and its own select/mode/enable slice.
module div_core_mc
   import div_pkg::*;
#(
   parameter int CH_NUM  = CH_NUM_DEF,
   parameter int SRC_NUM = SRC_NUM_DEF,
   parameter int DIV_W   = DIV_W_DEF,
   parameter int SEL_W   = SEL_W_DEF
) (
   input  logic                       clk_i,
   input  logic                       rst_n,
   input  logic [SRC_NUM*DIV_W-1:0]   src_data_i,
   input  logic [SRC_NUM-1:0]         src_done_i,
   input  logic [CH_NUM*SEL_W-1:0]    ch_sel_i,
   input  logic [CH_NUM-1:0]          ch_mode_i,
   input  logic [CH_NUM-1:0]          ch_en_i,
   output logic [CH_NUM-1:0]          div_en_o,
   output logic [CH_NUM-1:0]          div_clk_o
);

   for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
      div_chan #(
         .SRC_NUM (SRC_NUM),
         .DIV_W   (DIV_W),
         .SEL_W   (SEL_W)
      ) u_chan (
         .clk_i    (clk_i),
         .rst_n    (rst_n),
         .src_data (src_data_i),
         .src_done (src_done_i),
         .sel      (ch_sel_i[k*SEL_W +: SEL_W]),
         .mode     (ch_mode_i[k]),
         .en       (ch_en_i[k]),
         .div_en   (div_en_o[k]),
         .div_clk  (div_clk_o[k])
      );
   end

endmodule

// File: tb/tb_div_core_mc.sv
// Bench for div_core_mc: directed test-plan steps plus a random phase, every
// cycle checked against a period/phase reference model.
module tb_div_core_mc;
   import div_pkg::*;

   localparam int CH  = 4;
   localparam int SRC = 3;
   localparam int W   = 8;
   localparam int SW  = 2;

   logic              clk_i = 1'b0;
   logic              rst_n;
   logic [SRC*W-1:0]  src_data_i;
   logic [SRC-1:0]    src_done_i;
   logic [CH*SW-1:0]  ch_sel_i;
   logic [CH-1:0]     ch_mode_i;
   logic [CH-1:0]     ch_en_i;
   logic [CH-1:0]     div_en_o;
   logic [CH-1:0]     div_clk_o;

   int total = 0;
   int bad   = 0;

   // Reference: each channel is a period length, a phase within it and an optional queued length.
   int per_len [CH];
   int phase   [CH];
   int nxt     [CH];
   bit has_nxt [CH];
   logic [2*CH-1:0] exp_q [$];

   div_core_mc #(.CH_NUM(CH), .SRC_NUM(SRC), .DIV_W(W), .SEL_W(SW)) dut (
      .clk_i      (clk_i),
      .rst_n      (rst_n),
      .src_data_i (src_data_i),
      .src_done_i (src_done_i),
      .ch_sel_i   (ch_sel_i),
      .ch_mode_i  (ch_mode_i),
      .ch_en_i    (ch_en_i),
      .div_en_o   (div_en_o),
      .div_clk_o  (div_clk_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic model_clear();
      for (int k = 0; k < CH; k++) begin
         per_len[k] = 0;
         phase[k]   = 0;
         nxt[k]     = 0;
         has_nxt[k] = 0;
      end
   endtask

   // Advance the reference by one edge using the inputs that are stable at that edge.
   task automatic model_edge();
      logic [2*CH-1:0] e;
      int sel;
      int cap;
      e = '0;
      for (int k = 0; k < CH; k++) begin
         if (!rst_n || !ch_en_i[k]) begin
            per_len[k] = 0;
            phase[k]   = 0;
            nxt[k]     = 0;
            has_nxt[k] = 0;
         end else begin
            cap = -1;
            sel = int'(ch_sel_i[k*SW +: SW]);
            if (sel < SRC && src_done_i[sel]) cap = int'(src_data_i[sel*W +: W]);
            if (per_len[k] >= 2 && phase[k] < per_len[k] - 1) begin
               phase[k] = phase[k] + 1;
            end else begin
               if (has_nxt[k]) begin
                  per_len[k] = nxt[k];
                  has_nxt[k] = 0;
               end
               phase[k] = 0;
            end
            if (cap >= 0) begin
               nxt[k]     = cap;
               has_nxt[k] = 1;
            end
         end
         if (per_len[k] >= 2) begin
            e[CH+k] = 1'b1;
            e[k]    = ch_mode_i[k] ? (phase[k] == 0) : (phase[k] < (per_len[k] + 1) / 2);
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic check_model();
      logic [2*CH-1:0] e;
      e = exp_q.pop_front();
      total++;
      assert (div_en_o === e[2*CH-1:CH]) else begin
         bad++;
         $error("FAIL div_en_o observed=%b expected=%b t=%0t", div_en_o, e[2*CH-1:CH], $time);
      end
      total++;
      assert (div_clk_o === e[CH-1:0]) else begin
         bad++;
         $error("FAIL div_clk_o observed=%b expected=%b t=%0t", div_clk_o, e[CH-1:0], $time);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk_i);
      #1;
      check_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic collect(input int ch, input int n, output logic [31:0] bits);
      bits = '0;
      for (int i = 0; i < n; i++) begin
         tick();
         bits = {bits[30:0], div_clk_o[ch]};
      end
   endtask

   task automatic expect_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic done_pulse(input int src, input int val);
      src_data_i[src*W +: W] = W'(val);
      src_done_i             = '0;
      src_done_i[src]        = 1'b1;
      tick();
      src_done_i             = '0;
   endtask

   task automatic wait_phase(input int ch, input int ph);
      for (int i = 0; i < 20 && phase[ch] != ph; i++) tick();
      expect_bit("phase_reach", phase[ch] == ph, 1'b1);
   endtask

   initial begin
      logic [31:0] b;
      model_clear();
      rst_n      = 1'b0;
      src_data_i = '0;
      src_done_i = '0;
      ch_sel_i   = {2'd3, 2'd3, 2'd1, 2'd0};
      ch_mode_i  = '0;
      ch_en_i    = '1;
      #2;
      total++;
      assert (div_clk_o === '0 && div_en_o === '0) else begin
         bad++;
         $error("FAIL reset_state observed=%b/%b expected=0/0", div_en_o, div_clk_o);
      end
      ticks(2);
      #2 rst_n = 1'b1;
      ticks(2);

      // ch0 square, period 4, enable two clocks after the done pulse
      done_pulse(0, 4);
      expect_bit("ch0_en_latency1", div_en_o[0], 1'b0);
      tick();
      expect_bit("ch0_en_latency2", div_en_o[0], 1'b1);
      expect_bit("ch0_first_high", div_clk_o[0], 1'b1);
      collect(0, 8, b);
      total++;
      assert (b[7:0] === 8'b10011001) else begin
         bad++;
         $error("FAIL ch0_sq4 observed=%b expected=%b", b[7:0], 8'b10011001);
      end

      // ch1 square period 5, then pulse
      done_pulse(1, 5);
      tick();
      expect_bit("ch1_first_high", div_clk_o[1], 1'b1);
      collect(1, 10, b);
      total++;
      assert (b[9:0] === 10'b1100111001) else begin
         bad++;
         $error("FAIL ch1_sq5 observed=%b expected=%b", b[9:0], 10'b1100111001);
      end
      ch_mode_i[1] = MODE_PULSE;
      ticks(5);
      collect(1, 10, b);
      total++;
      assert ($countones(b[9:0]) == 2) else begin
         bad++;
         $error("FAIL ch1_pulse_count observed=%0d expected=2", $countones(b[9:0]));
      end

      // ch0 running at 4, load 6 while cnt=1: old period finishes fully
      wait_phase(0, 1);
      done_pulse(0, 6);
      ticks(2);
      expect_bit("ch0_p6_start", div_clk_o[0], 1'b1);
      collect(0, 6, b);
      total++;
      assert (b[5:0] === 6'b110001) else begin
         bad++;
         $error("FAIL ch0_sq6 observed=%b expected=%b", b[5:0], 6'b110001);
      end

      // two loads in one period: last wins
      wait_phase(0, 0);
      done_pulse(0, 7);
      tick();
      done_pulse(0, 3);
      ticks(20);

      // load 0 while running stops after the period; load 1 while stopped stays stopped
      done_pulse(0, 0);
      ticks(8);
      expect_bit("ch0_stop_en", div_en_o[0], 1'b0);
      expect_bit("ch0_stop_clk", div_clk_o[0], 1'b0);
      done_pulse(0, 1);
      ticks(4);
      expect_bit("ch0_load1_en", div_en_o[0], 1'b0);

      // simultaneous loads on different sources
      ch_mode_i[1] = MODE_SQUARE;
      ch_sel_i[1*SW +: SW] = 2'd2;
      src_data_i[0*W +: W] = 8'd2;
      src_data_i[2*W +: W] = 8'd8;
      src_done_i = 3'b101;
      tick();
      src_done_i = '0;
      ticks(20);
      collect(0, 4, b);
      total++;
      assert (b[3:0] === 4'b1010 || b[3:0] === 4'b0101) else begin
         bad++;
         $error("FAIL ch0_sq2 observed=%b expected=alternating", b[3:0]);
      end
      expect_bit("ch1_p8_running", div_en_o[1], 1'b1);

      // disable ch1
      ch_en_i[1] = 1'b0;
      tick();
      expect_bit("ch1_dis_clk", div_clk_o[1], 1'b0);
      expect_bit("ch1_dis_en", div_en_o[1], 1'b0);
      ch_en_i[1] = 1'b1;
      ticks(3);

      // asynchronous reset mid-period
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      total++;
      assert (div_clk_o === '0 && div_en_o === '0) else begin
         bad++;
         $error("FAIL async_reset observed=%b/%b expected=0/0", div_en_o, div_clk_o);
      end
      tick();
      #2 rst_n = 1'b1;
      ticks(10);
      total++;
      assert (div_en_o === '0) else begin
         bad++;
         $error("FAIL post_reset_idle observed=%b expected=0", div_en_o);
      end

      // random phase
      for (int n = 0; n < 600; n++) begin
         for (int s = 0; s < SRC; s++) begin
            src_data_i[s*W +: W] = W'($urandom_range(0, 12));
            src_done_i[s]        = ($urandom_range(0, 7) == 0);
         end
         for (int k = 0; k < CH; k++) begin
            if ($urandom_range(0, 29) == 0) ch_sel_i[k*SW +: SW] = SW'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) ch_mode_i[k] = ~ch_mode_i[k];
            if (ch_en_i[k]) begin
               if ($urandom_range(0, 79) == 0) ch_en_i[k] = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
               ch_en_i[k] = 1'b1;
            end
         end
         tick();
      end
      src_done_i = '0;
      ticks(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
